// File: rtl/baud_tick_generator.sv
// Fractional-divisor UART baud generator: rx_tick at OVERSAMPLE x baud, tx_tick at baud.
// Optional runtime divisor register (baudrate_sel 00) is built when BAUD_RUNTIME_DIV_EN is defined.
module baud_tick_generator #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned FRAC_WIDTH = 4,
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned BAUD_A     = 9600,
  parameter int unsigned BAUD_B     = 57600,
  parameter int unsigned BAUD_C     = 115200
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            enable,
  input  logic [1:0]                      baudrate_sel,
  input  logic                            div_load,
  input  logic [DIV_WIDTH+FRAC_WIDTH-1:0] div_value,
  output logic                            rx_tick,
  output logic                            tx_tick,
  output logic                            update_pending
);

  localparam int unsigned W   = DIV_WIDTH + FRAC_WIDTH;
  localparam int unsigned OSW = $clog2(OVERSAMPLE);

  localparam logic [W-1:0]   ONE     = W'(1) << FRAC_WIDTH;
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);

  // Rounded divisor for a preset rate, clamped to [1.0, max].
  function automatic logic [W-1:0] calc_div(
    input longint baud
  );
    longint den;
    longint num;
    longint d;
    longint lo;
    longint hi;
    lo  = longint'(1) << FRAC_WIDTH;
    hi  = (longint'(1) << W) - 1;
    den = baud * longint'(OVERSAMPLE);
    num = longint'(CLK_HZ) * lo + den / 2;
    d   = num / den;
    if (d < lo) d = lo;
    if (d > hi) d = hi;
    return W'(d);
  endfunction

  localparam logic [W-1:0] D_A = calc_div(longint'(BAUD_A));
  localparam logic [W-1:0] D_B = calc_div(longint'(BAUD_B));
  localparam logic [W-1:0] D_C = calc_div(longint'(BAUD_C));

  logic [W-1:0]   acc;
  logic [OSW-1:0] osc;
  logic [W-1:0]   d_active;
  logic [W-1:0]   d_sel;
  logic [W-1:0]   d_use;
  logic [W:0]     sum;
  logic           stopped;
  logic           run;
  logic           idle;
  logic           hit;
  logic           last;

`ifdef BAUD_RUNTIME_DIV_EN
  logic [W-1:0] custom;

  // Custom divisor, clamped on write so the engine never sees D < 1.0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      custom <= D_A;
    end else if (div_load) begin
      custom <= (div_value < ONE) ? ONE : div_value;
    end
  end
`else
  logic unused_div;
  assign unused_div = ^{div_load, div_value};
`endif

  // Divisor requested by baudrate_sel; sel 00 without the register stops the engine.
  always_comb begin
    d_sel   = D_A;
    stopped = 1'b0;
    unique case (baudrate_sel)
      2'b01: d_sel = D_A;
      2'b10: d_sel = D_B;
      2'b11: d_sel = D_C;
      default: begin
`ifdef BAUD_RUNTIME_DIV_EN
        d_sel = custom;
`else
        stopped = 1'b1;
`endif
      end
    endcase
  end

  assign run = enable && !stopped;

  // First enabled cycle after idle takes the selection directly; else the active divisor.
  always_comb begin
    d_use = idle ? d_sel : d_active;
    sum   = {1'b0, acc} + {1'b0, ONE};
    hit   = sum >= {1'b0, d_use};
    last  = osc == OS_LAST;
  end

  // Phase accumulator, oversample counter, tick outputs and bit-boundary divisor swap.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc      <= '0;
      osc      <= '0;
      rx_tick  <= 1'b0;
      tx_tick  <= 1'b0;
      d_active <= D_A;
      idle     <= 1'b1;
    end else if (!run) begin
      acc     <= '0;
      osc     <= '0;
      rx_tick <= 1'b0;
      tx_tick <= 1'b0;
      idle    <= 1'b1;
      if (!stopped) begin
        d_active <= d_sel;
      end
    end else begin
      idle    <= 1'b0;
      rx_tick <= hit;
      tx_tick <= hit && last;
      if (hit) begin
        acc <= W'(sum - {1'b0, d_use});
        osc <= osc + OSW'(1);
      end else begin
        acc <= W'(sum);
      end
      if (hit && last) begin
        d_active <= d_sel;
      end else begin
        d_active <= d_use;
      end
    end
  end

  assign update_pending = run && !idle && (d_sel != d_active);

endmodule

// File: tb/tb_baud_tick_generator.sv
// Self-checking bench for baud_tick_generator (default CLK_HZ/OVERSAMPLE/presets).
// Expected tick distances come from the fractional-divisor arithmetic: tick n at ceil(n*D/16).
module tb_baud_tick_generator;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  baudrate_sel = 2'b01;
  logic        div_load = 1'b0;
  logic [19:0] div_value = '0;
  logic        rx_tick;
  logic        tx_tick;
  logic        update_pending;

  int n_chk = 0;
  int n_fail = 0;
  int exp_q[$];

  baud_tick_generator dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .enable         (enable),
    .baudrate_sel   (baudrate_sel),
    .div_load       (div_load),
    .div_value      (div_value),
    .rx_tick        (rx_tick),
    .tx_tick        (tx_tick),
    .update_pending (update_pending)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Steps until the chosen tick is seen; n = steps taken, -1 on timeout.
  task automatic wait_tick(input bit tx, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if ((tx ? tx_tick : rx_tick) === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int n;
    int e;
    reset_n = 1'b0;
    enable = 1'b0;
    baudrate_sel = 2'b11;
    step();
    step();
    n_chk++;
    if ({rx_tick, tx_tick, update_pending} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_state: got %b expected 000",
               {rx_tick, tx_tick, update_pending});
    end
    reset_n = 1'b1;
    enable = 1'b1;
    repeat (100) step();
    wait_tick(1'b1, 600, n);
    baudrate_sel = 2'b01;
    #2;
    n_chk++;
    if ({rx_tick, tx_tick, update_pending} !== 3'b111) begin
      n_fail++;
      $display("FAIL pre_reset: got %b expected 111",
               {rx_tick, tx_tick, update_pending});
    end
    reset_n = 1'b0;
    #1;
    n_chk++;
    if ({rx_tick, tx_tick, update_pending} !== 3'b000) begin
      n_fail++;
      $display("FAIL async_reset: got %b expected 000",
               {rx_tick, tx_tick, update_pending});
    end
    step();
    reset_n = 1'b1;
    enable = 1'b0;
    step();
    enable = 1'b1;
    exp_q.push_back((5208 + 15) / 16);
    wait_tick(1'b0, 400, n);
    e = exp_q.pop_front();
    n_chk++;
    if (n !== e && n !== e - 1) begin
      n_fail++;
      $display("FAIL rx_first_a: got %0d expected %0d or %0d", n, e - 1, e);
    end
  endtask

  task automatic test_rate_c();
    int n;
    int e;
    int span;
    enable = 1'b0;
    baudrate_sel = 2'b11;
    step();
    enable = 1'b1;
    exp_q.push_back((434 + 15) / 16);
    wait_tick(1'b0, 100, n);
    e = exp_q.pop_front();
    n_chk++;
    if (n !== e && n !== e - 1) begin
      n_fail++;
      $display("FAIL rx_first_c: got %0d expected %0d or %0d", n, e - 1, e);
    end
    for (int g = 0; g < 2; g++) begin
      span = 0;
      for (int i = 0; i < 8; i++) begin
        exp_q.push_back(434 / 16);
        wait_tick(1'b0, 100, n);
        e = exp_q.pop_front();
        n_chk++;
        if (n !== e && n !== e + 1) begin
          n_fail++;
          $display("FAIL rx_interval_c: got %0d expected %0d or %0d", n, e, e + 1);
        end
        span += n;
      end
      exp_q.push_back(8 * 434 / 16);
      e = exp_q.pop_front();
      n_chk++;
      if (span !== e) begin
        n_fail++;
        $display("FAIL rx_span8_c: got %0d expected %0d", span, e);
      end
    end
    wait_tick(1'b1, 600, n);
    for (int i = 0; i < 10; i++) exp_q.push_back(434);
    for (int i = 0; i < 10; i++) begin
      wait_tick(1'b1, 600, n);
      e = exp_q.pop_front();
      n_chk++;
      if (n !== e) begin
        n_fail++;
        $display("FAIL tx_interval_c: got %0d expected %0d", n, e);
      end
    end
  endtask

  task automatic test_switch();
    int n;
    int e;
    int pend;
    int steps;
    bit seen;
    enable = 1'b0;
    baudrate_sel = 2'b01;
    step();
    enable = 1'b1;
    wait_tick(1'b1, 6000, n);
    repeat (1000) step();
    baudrate_sel = 2'b11;
    exp_q.push_back(5208 - 1000);
    exp_q.push_back(5208);
    exp_q.push_back(434);
    #1;
    pend = update_pending ? 1 : 0;
    steps = 1000;
    seen = 1'b0;
    for (int i = 0; i < 7000; i++) begin
      step();
      steps++;
      if (tx_tick === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (update_pending === 1'b1) pend++;
    end
    e = exp_q.pop_front();
    n_chk++;
    if (pend !== e) begin
      n_fail++;
      $display("FAIL pending_len: got %0d expected %0d", pend, e);
    end
    e = exp_q.pop_front();
    n_chk++;
    if (!seen || steps !== e) begin
      n_fail++;
      $display("FAIL switch_boundary: got %0d expected %0d", steps, e);
    end
    n_chk++;
    if (update_pending !== 1'b0) begin
      n_fail++;
      $display("FAIL pending_cleared: got %b expected 0", update_pending);
    end
    wait_tick(1'b1, 600, n);
    e = exp_q.pop_front();
    n_chk++;
    if (n !== e) begin
      n_fail++;
      $display("FAIL tx_after_switch: got %0d expected %0d", n, e);
    end
  endtask

  task automatic test_disable();
    int n;
    int e;
    int first_rx;
    int first_tx;
    baudrate_sel = 2'b11;
    wait_tick(1'b0, 100, n);
    wait_tick(1'b0, 100, n);
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++;
      if ({rx_tick, tx_tick, update_pending} !== 3'b000) begin
        n_fail++;
        $display("FAIL disabled_outputs: got %b expected 000",
                 {rx_tick, tx_tick, update_pending});
      end
    end
    enable = 1'b1;
    exp_q.push_back((434 + 15) / 16);
    exp_q.push_back(434);
    first_rx = -1;
    first_tx = -1;
    for (int i = 1; i <= 600; i++) begin
      step();
      if (rx_tick === 1'b1 && first_rx < 0) first_rx = i;
      if (tx_tick === 1'b1) begin
        first_tx = i;
        break;
      end
    end
    e = exp_q.pop_front();
    n_chk++;
    if (first_rx !== e && first_rx !== e - 1) begin
      n_fail++;
      $display("FAIL reenable_rx: got %0d expected %0d or %0d", first_rx, e - 1, e);
    end
    e = exp_q.pop_front();
    n_chk++;
    if (first_tx !== e) begin
      n_fail++;
      $display("FAIL reenable_tx: got %0d expected %0d", first_tx, e);
    end
  endtask

`ifdef BAUD_RUNTIME_DIV_EN
  task automatic test_custom();
    int n;
    int e;
    enable = 1'b0;
    baudrate_sel = 2'b00;
    div_value = 20'h00020;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 6; i++) exp_q.push_back(2);
    for (int i = 0; i < 6; i++) begin
      wait_tick(1'b0, 50, n);
      e = exp_q.pop_front();
      n_chk++;
      if (n !== e) begin
        n_fail++;
        $display("FAIL rx_custom32: got %0d expected %0d", n, e);
      end
    end
    wait_tick(1'b1, 100, n);
    for (int i = 0; i < 3; i++) exp_q.push_back(32);
    for (int i = 0; i < 3; i++) begin
      wait_tick(1'b1, 100, n);
      e = exp_q.pop_front();
      n_chk++;
      if (n !== e) begin
        n_fail++;
        $display("FAIL tx_custom32: got %0d expected %0d", n, e);
      end
    end
    repeat (5) step();
    div_value = 20'h00005;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    n_chk++;
    if (update_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL pending_after_load: got %b expected 1", update_pending);
    end
    wait_tick(1'b1, 100, n);
    for (int i = 0; i < 4; i++) exp_q.push_back(1);
    for (int i = 0; i < 4; i++) begin
      wait_tick(1'b0, 50, n);
      e = exp_q.pop_front();
      n_chk++;
      if (n !== e) begin
        n_fail++;
        $display("FAIL rx_clamped: got %0d expected %0d", n, e);
      end
    end
    wait_tick(1'b1, 100, n);
    for (int i = 0; i < 3; i++) exp_q.push_back(16);
    for (int i = 0; i < 3; i++) begin
      wait_tick(1'b1, 100, n);
      e = exp_q.pop_front();
      n_chk++;
      if (n !== e) begin
        n_fail++;
        $display("FAIL tx_clamped: got %0d expected %0d", n, e);
      end
    end
  endtask
`else
  task automatic test_stopped();
    int n;
    int e;
    int cnt;
    enable = 1'b1;
    baudrate_sel = 2'b00;
    div_value = 20'h00020;
    div_load = 1'b1;
    step();
    div_load = 1'b0;
    cnt = 0;
    exp_q.push_back(0);
    repeat (10000) begin
      step();
      if (rx_tick !== 1'b0 || tx_tick !== 1'b0 || update_pending !== 1'b0) cnt++;
    end
    e = exp_q.pop_front();
    n_chk++;
    if (cnt !== e) begin
      n_fail++;
      $display("FAIL stopped_activity: got %0d expected %0d", cnt, e);
    end
    baudrate_sel = 2'b10;
    exp_q.push_back((868 + 15) / 16);
    wait_tick(1'b0, 100, n);
    e = exp_q.pop_front();
    n_chk++;
    if (n !== e && n !== e - 1) begin
      n_fail++;
      $display("FAIL rx_first_b: got %0d expected %0d or %0d", n, e - 1, e);
    end
    for (int i = 0; i < 8; i++) exp_q.push_back(868 / 16);
    for (int i = 0; i < 8; i++) begin
      wait_tick(1'b0, 100, n);
      e = exp_q.pop_front();
      n_chk++;
      if (n !== e && n !== e + 1) begin
        n_fail++;
        $display("FAIL rx_interval_b: got %0d expected %0d or %0d", n, e, e + 1);
      end
    end
    wait_tick(1'b1, 1000, n);
    for (int i = 0; i < 3; i++) exp_q.push_back(868);
    for (int i = 0; i < 3; i++) begin
      wait_tick(1'b1, 1000, n);
      e = exp_q.pop_front();
      n_chk++;
      if (n !== e) begin
        n_fail++;
        $display("FAIL tx_interval_b: got %0d expected %0d", n, e);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_rate_c();
    test_switch();
    test_disable();
`ifdef BAUD_RUNTIME_DIV_EN
    test_custom();
`else
    test_stopped();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
